// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-256 packet transmitter: state encoding,
// packet/byte widths and the default message-length counter width.
package sha2_pkg;

   localparam int PKT_W     = 64;
   localparam int BYTE_W    = 8;
   localparam int LANES     = PKT_W / BYTE_W;
   localparam int LEN_W_DEF = 64;

   typedef enum logic [1:0] {
      FILL_ST = 2'd0,
      SEND_ST = 2'd1,
      END_ST  = 2'd2
   } txState_e;

endpackage

// File: rtl/sha2pkttx.sv
// Packs a byte stream into big-endian 64-bit packets for the SHA-256 input
// stage, tracking message length in bits and the byte count of the last packet.
module sha2pkttx
   import sha2_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic [BYTE_W-1:0]   byte_in,
   input  logic                byte_val,
   input  logic                byte_lst,
   output logic                byte_rdy,
   output logic [PKT_W-1:0]    pkt,
   output logic                pkt_val,
   input  logic                pkt_rdy,
   output logic                lst_pkt,
   output logic [3:0]          lst_nb,
   output logic [LEN_W-1:0]    msg_len,
   output logic                msg_end
);

   txState_e          state_q, state_d;
   logic [PKT_W-1:0]  pkt_q, pkt_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              lstPkt_q, lstPkt_d;
   logic [3:0]        lstNb_q, lstNb_d;
   logic [LEN_W-1:0]  msgLen_q, msgLen_d;

   // clr aborts exactly like rst, overriding any handoff in the same cycle
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state_q  <= FILL_ST;
         pkt_q    <= '0;
         cnt_q    <= '0;
         lstPkt_q <= 1'b0;
         lstNb_q  <= '0;
         msgLen_q <= '0;
      end else begin
         state_q  <= state_d;
         pkt_q    <= pkt_d;
         cnt_q    <= cnt_d;
         lstPkt_q <= lstPkt_d;
         lstNb_q  <= lstNb_d;
         msgLen_q <= msgLen_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pkt_d    = pkt_q;
      cnt_d    = cnt_q;
      lstPkt_d = lstPkt_q;
      lstNb_d  = lstNb_q;
      msgLen_d = msgLen_q;
      case (state_q)
         FILL_ST: begin
            if (byte_val) begin
               // lane 0 is the most significant byte of the packet
               for (int i = 0; i < LANES; i++) begin
                  if (cnt_q == 3'(i)) begin
                     pkt_d[PKT_W-1-BYTE_W*i -: BYTE_W] = byte_in;
                  end
               end
               cnt_d    = cnt_q + 3'd1;
               msgLen_d = msgLen_q + LEN_W'(BYTE_W);
               if (byte_lst) begin
                  lstPkt_d = 1'b1;
                  lstNb_d  = {1'b0, cnt_q} + 4'd1;
               end
               if (byte_lst || cnt_q == 3'd7) begin
                  state_d = SEND_ST;
               end
            end
         end
         SEND_ST: begin
            if (pkt_rdy) begin
               if (lstPkt_q) begin
                  state_d = END_ST;
               end else begin
                  pkt_d   = '0;
                  cnt_d   = '0;
                  state_d = FILL_ST;
               end
            end
         end
         END_ST: begin
            pkt_d    = '0;
            cnt_d    = '0;
            lstPkt_d = 1'b0;
            lstNb_d  = '0;
            msgLen_d = '0;
            state_d  = FILL_ST;
         end
         default: state_d = FILL_ST;
      endcase
   end

   assign byte_rdy = (state_q == FILL_ST);
   assign pkt_val  = (state_q == SEND_ST);
   assign msg_end  = (state_q == END_ST);
   assign pkt      = pkt_q;
   assign lst_pkt  = lstPkt_q;
   assign lst_nb   = lstNb_q;
   assign msg_len  = msgLen_q;

endmodule
